multicycle_addsub: RTL and testbench
====================================

# multicycle_addsub

Parametrised, slice-serial two's-complement adder/subtractor for the ALU datapath. Takes WIDTH-bit operands through a valid/ready handshake and computes the result SLICE bits per clock, carrying between slices in a registered carry flop. Produces sum, carry-out, signed overflow and zero flags. It trades latency for area against the fully combinational 8-bit ripple adder, and scales to 32-bit and wider datapaths.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- SLICE, 8, bits processed per cycle. Must divide WIDTH; NSLICE = WIDTH/SLICE.
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and `sub` are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  output  1  result and flags are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH−1. For subtract, 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  s == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready at an edge:
  - latch A, and B XOR {WIDTH{sub}};
  - load the carry flop with sub;
  - clear the slice counter;
  - go to RUN.
- RUN: each edge adds the current SLICE-bit slice of A and B' with the carry flop.
  - Slices are processed LSB slice first.
  - The slice sum is written into its result position; the carry flop takes the slice carry-out; the counter increments.
  - On the edge that processes slice NSLICE−1:
    - register cout = final carry;
    - register overflow = carry into bit WIDTH−1 XOR final carry;
    - register zero from the complete result;
    - go to DONE.
- DONE: out_valid=1. s, cout, overflow and zero are stable until out_valid&&out_ready at an edge, then go to IDLE.
- in_valid is ignored outside IDLE; operands are not re-sampled after acceptance.
- in_ready and out_valid are never high in the same cycle, so there is no back-to-back overlap.
- SLICE == WIDTH is legal: RUN lasts exactly one cycle.
- Arithmetic is purely modulo 2^WIDTH; there is no saturation.

## Timing
- Reset (async assert, state goes to IDLE immediately):
  - in_ready=1, out_valid=0;
  - s=0, cout=0, overflow=0, zero=0;
  - carry flop and counter are cleared.
- Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- Latency: acceptance at edge 0 gives out_valid high after edge NSLICE, i.e. NSLICE cycles.
- If out_ready is already high, in_ready rises after edge NSLICE+1.
- Minimum issue interval: NSLICE+2 cycles.
- Backpressure: out_valid stays high and all outputs are held indefinitely while out_ready=0.
- out_ready is don't-care when out_valid=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
1. WIDTH=32, SLICE=8: a=0x7FFFFFFF, b=0x00000001, sub=0 → s=0x80000000, cout=0, overflow=1, zero=0. out_valid rises exactly 4 cycles after acceptance.
2. WIDTH=32, SLICE=8: a=0xFFFFFFFF, b=0x00000001, sub=0 → s=0, cout=1, overflow=0, zero=1. Then a=5, b=5, sub=1 → s=0, cout=1, zero=1. Then a=3, b=5, sub=1 → s=0xFFFFFFFE, cout=0, overflow=0.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs unchanged, in_ready=0 throughout. While in DONE, drive in_valid=1 with new operands → they are ignored. Release out_ready → in_ready=1 on the next cycle.
4. Reset mid-operation: deassert reset_n during RUN slice 2 → outputs immediately at reset values. After release, a fresh a=0x80000000, b=0x80000000, sub=0 → s=0, cout=1, overflow=1.
5. Parameter sweep (WIDTH,SLICE) = (8,8), (8,1), (32,4), (64,16):
   - 1000 random operations each with random in_valid/out_ready gaps;
   - check s/cout/overflow/zero against a behavioural model;
   - check latency is exactly WIDTH/SLICE cycles.

Source files
------------

// File: rtl/multicycle_addsub_if.sv
// Operand/result handshake bundle for the slice-serial adder/subtractor.
interface multicycle_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, overflow, zero
  );
endinterface

// File: rtl/multicycle_addsub.sv
// Slice-serial two's-complement adder/subtractor: SLICE bits per clock,
// carry held in a flop between slices, registered result and flags.
module multicycle_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  multicycle_addsub_if.slave bus
);
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;

  logic [31:0]      base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] sum_sl;
  logic             carry_sl;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;

  // Result is accumulated privately so s only changes when a full result lands.
  always_comb begin
    base              = 32'(cnt_q) * SLICE;
    a_sl              = a_q[base +: SLICE];
    b_sl              = b_q[base +: SLICE];
    {carry_sl, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    res_next          = acc_q;
    res_next[base +: SLICE] = sum_sl;
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    msb_cin           = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_next[WIDTH-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b ^ {WIDTH{bus.sub}};
            carry_q    <= bus.sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc_q   <= res_next;
          carry_q <= carry_sl;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q         <= res_next;
            cout_q      <= carry_sl;
            overflow_q  <= msb_cin ^ carry_sl;
            zero_q      <= (res_next == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench: directed checks on a 32/8 instance plus random sweeps
// over several WIDTH/SLICE combinations.
module tb_multicycle_addsub;
  logic        clock = 1'b0;
  logic        rst_main;
  logic        rst_sw;
  logic        sw_go = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Packed as {zero, overflow, cout, s[63:0]}.
  function automatic logic [66:0] model(input int unsigned w, input logic [63:0] a,
                                        input logic [63:0] b, input logic sub);
    logic [63:0] mask, aa, bb, ss;
    logic [64:0] full;
    logic        co, ov;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + 65'(sub);
    ss   = full[63:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
    return {(ss == '0), ov, co, ss};
  endfunction

  // ---------------- directed instance, WIDTH=32 SLICE=8 ----------------
  multicycle_addsub_if #(.WIDTH(32)) m_if();
  multicycle_addsub #(.WIDTH(32), .SLICE(8)) u_main (
    .clock  (clock),
    .reset_n(rst_main),
    .bus    (m_if)
  );

  logic [66:0] mq[$];
  logic [66:0] m_last;

  task automatic m_issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int unsigned k;
    k = 0;
    while (!m_if.in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("m_issue_ready", m_if.in_ready, 1);
    m_if.a        = a;
    m_if.b        = b;
    m_if.sub      = sub;
    m_if.in_valid = 1'b1;
    mq.push_back(model(32, 64'(a), 64'(b), sub));
    @(negedge clock);
    m_if.in_valid = 1'b0;
  endtask

  task automatic m_wait_result();
    int unsigned lat;
    logic [66:0] e;
    lat = 0;
    while (!m_if.out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    check("m_latency", 64'(lat), 64'd4);
    e = '0;
    if (mq.size() == 0) check("m_queue_empty", 1, 0);
    else e = mq.pop_front();
    m_last = e;
    check("m_s", m_if.s, e[31:0]);
    check("m_cout", m_if.cout, e[64]);
    check("m_overflow", m_if.overflow, e[65]);
    check("m_zero", m_if.zero, e[66]);
  endtask

  task automatic m_consume();
    m_if.out_ready = 1'b1;
    @(negedge clock);
    m_if.out_ready = 1'b0;
    check("m_in_ready_after", m_if.in_ready, 1);
    check("m_out_valid_after", m_if.out_valid, 0);
  endtask

  // ---------------- random sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned W = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 32 : 64;
    localparam int unsigned S = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 16;
    localparam int unsigned NOPS = 1000;

    multicycle_addsub_if #(.WIDTH(W)) sif();
    multicycle_addsub #(.WIDTH(W), .SLICE(S)) u_dut (
      .clock  (clock),
      .reset_n(rst_sw),
      .bus    (sif)
    );

    logic [66:0] exp_q[$];
    int unsigned acc_q[$];
    int unsigned cyc = 0;
    logic        done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        default: return W'({$urandom(), $urandom()});
      endcase
    endfunction

    initial begin : drive
      logic [W-1:0] ra, rb;
      logic         rs;
      sif.in_valid = 1'b0;
      sif.a        = '0;
      sif.b        = '0;
      sif.sub      = 1'b0;
      wait (sw_go);
      for (int n = 0; n < NOPS; n++) begin
        int unsigned k;
        repeat ($urandom_range(0, 3)) @(negedge clock);
        @(negedge clock);
        k = 0;
        while (!sif.in_ready && k < 1000) begin
          @(negedge clock);
          k++;
        end
        check($sformatf("w%0d_s%0d ready", W, S), sif.in_ready, 1);
        if (!sif.in_ready) break;
        ra = pick();
        rb = pick();
        rs = 1'($urandom_range(0, 1));
        sif.a        = ra;
        sif.b        = rb;
        sif.sub      = rs;
        sif.in_valid = 1'b1;
        exp_q.push_back(model(W, 64'(ra), 64'(rb), rs));
        acc_q.push_back(cyc + 1);
        @(negedge clock);
        sif.in_valid = 1'b0;
      end
    end

    initial begin : monitor
      logic        prev;
      int unsigned got_n, k, ac;
      logic [66:0] e;
      prev  = 1'b0;
      got_n = 0;
      k     = 0;
      sif.out_ready = 1'b0;
      wait (sw_go);
      while (got_n < NOPS && k < 60000) begin
        @(negedge clock);
        k++;
        if (sif.out_valid && !prev) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            check($sformatf("w%0d_s%0d spurious_valid", W, S), 1, 0);
          end else begin
            e  = exp_q.pop_front();
            ac = acc_q.pop_front();
            check($sformatf("w%0d_s%0d latency", W, S), 64'(cyc - ac), 64'(W / S));
            check($sformatf("w%0d_s%0d s", W, S), 64'(sif.s), e[63:0]);
            check($sformatf("w%0d_s%0d cout", W, S), sif.cout, e[64]);
            check($sformatf("w%0d_s%0d overflow", W, S), sif.overflow, e[65]);
            check($sformatf("w%0d_s%0d zero", W, S), sif.zero, e[66]);
          end
          got_n++;
        end
        prev = sif.out_valid;
        sif.out_ready = 1'($urandom_range(0, 1));
      end
      check($sformatf("w%0d_s%0d completed", W, S), 64'(got_n), 64'(NOPS));
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic all_done;
    m_if.in_valid  = 1'b0;
    m_if.a         = '0;
    m_if.b         = '0;
    m_if.sub       = 1'b0;
    m_if.out_ready = 1'b0;
    rst_main = 1'b1;
    rst_sw   = 1'b1;
    #2;
    rst_main = 1'b0;
    rst_sw   = 1'b0;
    #1;
    check("rst_in_ready", m_if.in_ready, 1);
    check("rst_out_valid", m_if.out_valid, 0);
    check("rst_s", m_if.s, 0);
    check("rst_cout", m_if.cout, 0);
    check("rst_overflow", m_if.overflow, 0);
    check("rst_zero", m_if.zero, 0);
    repeat (2) @(negedge clock);
    rst_main = 1'b1;
    rst_sw   = 1'b1;
    sw_go    = 1'b1;
    @(negedge clock);

    // Signed overflow on positive + positive.
    m_issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    m_wait_result();
    check("t1_s_literal", m_if.s, 32'h8000_0000);
    check("t1_ovf_literal", m_if.overflow, 1);
    m_consume();

    m_issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    m_wait_result();
    m_consume();
    m_issue(32'd5, 32'd5, 1'b1);
    m_wait_result();
    m_consume();
    m_issue(32'd3, 32'd5, 1'b1);
    m_wait_result();
    check("t2_s_literal", m_if.s, 32'hFFFF_FFFE);
    m_consume();

    // Backpressure with stray operands offered while DONE.
    m_issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    m_wait_result();
    for (int i = 0; i < 10; i++) begin
      m_if.a        = 32'hFFFF_FFFF;
      m_if.b        = 32'h0000_0001;
      m_if.sub      = 1'b1;
      m_if.in_valid = 1'b1;
      @(negedge clock);
      check("bp_s", m_if.s, m_last[31:0]);
      check("bp_cout", m_if.cout, m_last[64]);
      check("bp_overflow", m_if.overflow, m_last[65]);
      check("bp_zero", m_if.zero, m_last[66]);
      check("bp_out_valid", m_if.out_valid, 1);
      check("bp_in_ready", m_if.in_ready, 0);
    end
    m_if.in_valid = 1'b0;
    m_consume();
    @(negedge clock);
    check("bp_no_capture", m_if.in_ready, 1);

    // Abort during slice 2.
    m_issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    repeat (2) @(negedge clock);
    rst_main = 1'b0;
    #1;
    check("abort_in_ready", m_if.in_ready, 1);
    check("abort_out_valid", m_if.out_valid, 0);
    check("abort_s", m_if.s, 0);
    check("abort_cout", m_if.cout, 0);
    check("abort_overflow", m_if.overflow, 0);
    check("abort_zero", m_if.zero, 0);
    if (mq.size() != 0) void'(mq.pop_back());
    @(negedge clock);
    rst_main = 1'b1;
    @(negedge clock);
    check("abort_idle_out_valid", m_if.out_valid, 0);
    m_issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    m_wait_result();
    check("t4_cout_literal", m_if.cout, 1);
    m_consume();

    all_done = 1'b0;
    for (int k = 0; k < 80000; k++) begin
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done;
      if (all_done) break;
      @(negedge clock);
    end
    check("sweep_all_done", all_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
